writeback_stage: RTL and testbench
==================================

# writeback_stage

Parametrised final pipeline stage of the RISC-V core. It registers the memory-stage bundle under a valid/ready handshake with stall and flush control. It then selects the result (ALU, extended load data, PC+4 or immediate) and drives the register-file write port and forwarding bus. It also maintains a retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 64, width of retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- m_valid  in  1  memory stage presents a valid instruction.
- m_ready  out  1  stage accepts this cycle; equals !stall.
- stall  in  1  hazard-unit hold of the W register.
- flush  in  1  kill W-register contents.
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate.
- LoadTypeM  in  3  load funct3.
- ByteOffM  in  log2(XLEN/8)  low address bits of the load.
- RegWriteM  in  1  instruction writes rd.
- RdM  in  5  destination register.
- ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM  in  XLEN  result sources.
- ResultW  out  XLEN  write-back data.
- RdW  out  5  registered rd.
- RegWriteW  out  1  register-file write enable.
- wb_valid  out  1  W register holds a live instruction.
- instret  out  CNT_W  retired-instruction count.

## Operation
- The W register holds valid, ResultSrc, LoadType, ByteOff, RegWrite, Rd and the four XLEN sources.
- Capture occurs when m_valid && m_ready. The next wb_valid equals m_valid when !stall.
- Priority each edge is: reset > flush > stall > capture.
  - flush sets wb_valid=0; data fields are don't-care.
  - stall holds every field.
  - Otherwise all fields load and wb_valid=m_valid.
- ResultW is combinational from the W register:
  - 00: ALU_Result.
  - 01: extended load.
  - 10: PCPlus4.
  - 11: ImmExt.
- Load extension (ReadData is the naturally aligned XLEN-bit bus):
  - 000 LB / 100 LBU: byte ReadData[8*off +: 8], sign- or zero-extended.
  - 001 LH / 101 LHU: halfword at offset with bit0 cleared, sign- or zero-extended.
  - 010 LW: word at offset with bits[1:0] cleared, sign-extended.
  - XLEN=64 only:
    - 110 LWU: word at offset with bits[1:0] cleared, zero-extended.
    - 011 LD: full word.
  - All other codes, including 011/110 when XLEN=32: ResultW = ReadData unmodified.
- RegWriteW = wb_valid && RegWrite && (RdW != 0). x0 writes are suppressed; ResultW is still driven.
- instret increments by 1 on every edge where wb_valid=1 and stall=0, regardless of RegWrite. It wraps modulo 2^CNT_W and counts each instruction exactly once even across multi-cycle stalls.

## Timing
- Reset values:
  - wb_valid=0, RegWriteW=0, RdW=0, ResultW=0.
  - instret=0; all stored fields zero.
  - m_ready = !stall during reset, combinational.
- Latency: 1 cycle. M-stage inputs at edge N appear on ResultW/RegWriteW after edge N and are consumed by the register file at edge N+1.
- Stalled instruction: presents identical ResultW/RegWriteW each stalled cycle; the register-file write repeats idempotently. It retires on the first unstalled edge.
- Flush with stall asserted: flush wins; the instruction is dropped without incrementing instret.
- Reset mid-stall or mid-flush: reset wins; the counter clears.
- instret at all-ones plus a retire wraps to 0 in the same edge.

## Test plan
- Reset: hold rst=0 for 2 cycles with m_valid=1 -> wb_valid=0, RegWriteW=0, instret=0. Release -> first instruction visible one cycle later.
- Result mux, XLEN=32: ALU=0x11, PC+4=0x104, Imm=0x12345000, ResultSrc 00/10/11 on rd=5 -> ResultW 0x11/0x104/0x12345000, RegWriteW=1, RdW=5.
- Loads: ReadData=0x80F0_7F81.
  - LB off=0 -> 0xFFFFFF81.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80F0.
  - LHU off=0 -> 0x00007F81.
  - LW -> 0x80F07F81.
- x0 and stall: rd=0 with RegWrite=1 -> RegWriteW=0, instret increments. 3-cycle stall -> outputs held, instret +1 only once.
- Flush: flush with stall on a live instruction -> wb_valid=0 next cycle, instret unchanged. Simultaneous flush and capture -> instruction dropped.
- Counter wrap: CNT_W=4, retire 17 instructions -> instret=1.

Source files
------------

// File: rtl/writeback_stage.sv
// Final pipeline stage: W register with valid/ready, stall and flush, result
// selection with load extension, register-file write port and retired counter.
module writeback_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  output logic                       m_ready,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [1:0]                 ResultSrcM,
  input  logic [2:0]                 LoadTypeM,
  input  logic [$clog2(XLEN/8)-1:0]  ByteOffM,
  input  logic                       RegWriteM,
  input  logic [4:0]                 RdM,
  input  logic [XLEN-1:0]            ALU_ResultM,
  input  logic [XLEN-1:0]            ReadDataM,
  input  logic [XLEN-1:0]            PCPlus4M,
  input  logic [XLEN-1:0]            ImmExtM,
  output logic [XLEN-1:0]            ResultW,
  output logic [4:0]                 RdW,
  output logic                       RegWriteW,
  output logic                       wb_valid,
  output logic [CNT_W-1:0]           instret
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam logic [OFF_W-1:0] H_MASK = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] W_MASK = ~OFF_W'(3);

  logic              valid_q;
  logic [1:0]        src_q;
  logic [2:0]        ltype_q;
  logic [OFF_W-1:0]  off_q;
  logic              regwrite_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   alu_q, rdata_q, pc4_q, imm_q;
  logic [CNT_W-1:0]  instret_q;

  assign m_ready = !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      src_q      <= '0;
      ltype_q    <= '0;
      off_q      <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (flush) begin
      // Data fields are left as-is; only the valid bit matters once killed.
      valid_q    <= 1'b0;
    end else if (!stall) begin
      valid_q    <= m_valid;
      src_q      <= ResultSrcM;
      ltype_q    <= LoadTypeM;
      off_q      <= ByteOffM;
      regwrite_q <= RegWriteM;
      rd_q       <= RdM;
      alu_q      <= ALU_ResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      imm_q      <= ImmExtM;
    end
  end

  // An instruction retires on the edge it leaves W, so a stall never double-counts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (valid_q && !stall) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  logic [XLEN-1:0] sh_b, sh_h, sh_w, load_ext;
  logic [7:0]      b_v;
  logic [15:0]     h_v;
  logic [31:0]     w_v;

  always_comb begin
    sh_b = rdata_q >> {off_q, 3'b000};
    sh_h = rdata_q >> {off_q & H_MASK, 3'b000};
    sh_w = rdata_q >> {off_q & W_MASK, 3'b000};
    b_v  = sh_b[7:0];
    h_v  = sh_h[15:0];
    w_v  = sh_w[31:0];
    load_ext = rdata_q;
    case (ltype_q)
      3'b000: load_ext = XLEN'($signed(b_v));
      3'b100: load_ext = XLEN'(b_v);
      3'b001: load_ext = XLEN'($signed(h_v));
      3'b101: load_ext = XLEN'(h_v);
      3'b010: load_ext = XLEN'($signed(w_v));
      3'b110: if (XLEN == 64) load_ext = XLEN'(w_v);
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    ResultW = alu_q;
    case (src_q)
      2'b00: ResultW = alu_q;
      2'b01: ResultW = load_ext;
      2'b10: ResultW = pc4_q;
      2'b11: ResultW = imm_q;
      default: ResultW = alu_q;
    endcase
  end

  assign RdW       = rd_q;
  assign wb_valid  = valid_q;
  assign RegWriteW = valid_q && regwrite_q && (rd_q != 5'd0);
  assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: result mux, load extension, x0, stall,
// flush, reset and retired-counter wrap (second instance with a 4-bit counter).
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, stall, flush;
  logic [1:0]  ResultSrcM;
  logic [2:0]  LoadTypeM;
  logic [1:0]  ByteOffM;
  logic        RegWriteM;
  logic [4:0]  RdM;
  logic [31:0] ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM;

  logic        m_ready, RegWriteW, wb_valid;
  logic [31:0] ResultW;
  logic [4:0]  RdW;
  logic [63:0] instret;

  logic        s_m_ready, s_RegWriteW, s_wb_valid;
  logic [31:0] s_ResultW;
  logic [4:0]  s_RdW;
  logic [3:0]  s_instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
    .stall(stall), .flush(flush), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
    .ByteOffM(ByteOffM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
    .wb_valid(wb_valid), .instret(instret)
  );

  writeback_stage #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(s_m_ready),
    .stall(stall), .flush(flush), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
    .ByteOffM(ByteOffM), .RegWriteM(RegWriteM), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .ResultW(s_ResultW), .RdW(s_RdW), .RegWriteW(s_RegWriteW),
    .wb_valid(s_wb_valid), .instret(s_instret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
    $display("check %-14s observed %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] src, input logic [2:0] lt, input logic [1:0] off,
                      input logic rw, input logic [4:0] rd, input logic [31:0] alu);
    m_valid     = 1'b1;
    ResultSrcM  = src;
    LoadTypeM   = lt;
    ByteOffM    = off;
    RegWriteM   = rw;
    RdM         = rd;
    ALU_ResultM = alu;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    ReadDataM = 32'h80F0_7F81; PCPlus4M = 32'h104; ImmExtM = 32'h1234_5000;
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd5, 32'h11);

    // Reset held two cycles with m_valid high
    step(); step();
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_regwrite", 64'(RegWriteW), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_result", 64'(ResultW), 64'd0);
    chk("rst_rd", 64'(RdW), 64'd0);
    chk("rst_ready", 64'(m_ready), 64'd1);
    stall = 1'b1; #1;
    chk("rst_ready_stl", 64'(m_ready), 64'd0);
    stall = 1'b0;

    // Result mux
    rst = 1'b1;
    step();
    chk("alu_result", 64'(ResultW), 64'h11);
    chk("alu_regwrite", 64'(RegWriteW), 64'd1);
    chk("alu_rd", 64'(RdW), 64'd5);
    chk("alu_valid", 64'(wb_valid), 64'd1);
    chk("alu_instret", instret, 64'd0);
    send(2'b10, 3'b000, 2'd0, 1'b1, 5'd5, 32'h11); step();
    chk("pc4_result", 64'(ResultW), 64'h104);
    chk("pc4_instret", instret, 64'd1);
    send(2'b11, 3'b000, 2'd0, 1'b1, 5'd5, 32'h11); step();
    chk("imm_result", 64'(ResultW), 64'h1234_5000);
    chk("imm_instret", instret, 64'd2);

    // Loads on 0x80F07F81
    send(2'b01, 3'b000, 2'd0, 1'b1, 5'd6, 32'h0); step();
    chk("lb_off0", 64'(ResultW), 64'hFFFF_FF81);
    send(2'b01, 3'b100, 2'd3, 1'b1, 5'd6, 32'h0); step();
    chk("lbu_off3", 64'(ResultW), 64'h0000_0080);
    send(2'b01, 3'b001, 2'd2, 1'b1, 5'd6, 32'h0); step();
    chk("lh_off2", 64'(ResultW), 64'hFFFF_80F0);
    send(2'b01, 3'b101, 2'd0, 1'b1, 5'd6, 32'h0); step();
    chk("lhu_off0", 64'(ResultW), 64'h0000_7F81);
    send(2'b01, 3'b010, 2'd0, 1'b1, 5'd6, 32'h0); step();
    chk("lw", 64'(ResultW), 64'h80F0_7F81);
    chk("lw_instret", instret, 64'd7);

    // x0 destination
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd0, 32'h22); step();
    chk("x0_regwrite", 64'(RegWriteW), 64'd0);
    chk("x0_result", 64'(ResultW), 64'h22);
    chk("x0_valid", 64'(wb_valid), 64'd1);
    chk("x0_instret", instret, 64'd8);

    // Three-cycle stall on instruction A
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd7, 32'h33); step();
    chk("a_instret", instret, 64'd9);
    stall = 1'b1;
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd8, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_result", 64'(ResultW), 64'h33);
      chk("stl_rd", 64'(RdW), 64'd7);
      chk("stl_regwrite", 64'(RegWriteW), 64'd1);
      chk("stl_instret", instret, 64'd9);
      chk("stl_ready", 64'(m_ready), 64'd0);
    end
    stall = 1'b0; step();
    chk("b_result", 64'(ResultW), 64'h44);
    chk("b_instret", instret, 64'd10);

    // Flush while stalled drops B without retiring it
    stall = 1'b1; flush = 1'b1;
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd9, 32'h55); step();
    chk("fs_valid", 64'(wb_valid), 64'd0);
    chk("fs_regwrite", 64'(RegWriteW), 64'd0);
    chk("fs_instret", instret, 64'd10);
    stall = 1'b0; flush = 1'b0; m_valid = 1'b0; step();
    chk("idle_valid", 64'(wb_valid), 64'd0);
    chk("idle_instret", instret, 64'd10);

    // Flush together with capture
    flush = 1'b1;
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd10, 32'h66); step();
    chk("fc_valid", 64'(wb_valid), 64'd0);
    flush = 1'b0; m_valid = 1'b0; step();
    chk("fc_instret", instret, 64'd10);

    // Reset in the middle of a stall
    send(2'b00, 3'b000, 2'd0, 1'b1, 5'd11, 32'h77); step();
    chk("e_valid", 64'(wb_valid), 64'd1);
    stall = 1'b1; rst = 1'b0; step();
    chk("rs_valid", 64'(wb_valid), 64'd0);
    chk("rs_instret", instret, 64'd0);

    // Retire 17 instructions; the 4-bit counter wraps to 1
    rst = 1'b1; stall = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(2'b00, 3'b000, 2'd0, 1'b1, 5'd1, 32'(i));
      step();
    end
    m_valid = 1'b0; step();
    chk("wrap_big", instret, 64'd17);
    chk("wrap_small", 64'(s_instret), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
